pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_core.sv | 46 ++++
 rtl/pwm_ramp_ctrl.sv | 147 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller.
// Holds the default widths and the ramp FSM state encoding used by pwm_ramp_ctrl.
package pwm_pkg;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefIvlWidth = 8;

    // Ramp FSM states; plain constants keep the encoding visible to legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StRamp = 2'd1;
    localparam state_t StHold = 2'd2;

endpackage

// File: rtl/pwm_core.sv
// PWM period counter and comparator.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   enable_i        - runs the counter; counter held at 0 while low
//   duty_i          - duty applied to the compare
//   wrap_o          - last cycle of the period (enable and cnt at max)
//   period_start_o  - high while cnt is 0 and enable is high
//   pwm_o           - registered enable & (cnt < duty)
module pwm_core
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] duty_i,
    output logic             wrap_o,
    output logic             period_start_o,
    output logic             pwm_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        cnt_d = enable_i ? cnt_q + WIDTH'(1) : '0;
        pwm_d = enable_i & (cnt_q < duty_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign wrap_o         = enable_i & (cnt_q == '1);
    // Gated by rst_n so the pulse is forced low while reset is held.
    assign period_start_o = rst_n & enable_i & (cnt_q == '0);
    assign pwm_o          = pwm_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with a period-aligned duty ramp toward a requested target.
// Optional feature macro: PWM_RAMP_DONE_IRQ_EN adds done_irq, a one-cycle pulse on every
// arrival in HOLD (ramp completion or a request that needs no ramp).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   enable                     - runs the period counter, gates pwm, aborts ramps when low
//   tgt_valid / tgt_ready      - request handshake
//   tgt_duty, tgt_step, tgt_ivl - target duty, step size (0 means 1), extra periods per step
//   duty_cur                   - duty currently applied
//   pwm, period_start, busy    - waveform, period-start pulse, ramp in progress
//   done_irq (optional)        - arrival-in-HOLD pulse
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned IVL_WIDTH = DefIvlWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [WIDTH-1:0]     tgt_duty,
    input  logic [WIDTH-1:0]     tgt_step,
    input  logic [IVL_WIDTH-1:0] tgt_ivl,
    output logic [WIDTH-1:0]     duty_cur,
    output logic                 pwm,
    output logic                 period_start,
    output logic                 busy
`ifdef PWM_RAMP_DONE_IRQ_EN
    ,
    output logic                 done_irq
`endif
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     duty_q, duty_d;
    logic [WIDTH-1:0]     tgt_q, tgt_d;
    logic [WIDTH-1:0]     step_q, step_d;
    logic [IVL_WIDTH-1:0] ivl_q, ivl_d;
    logic [IVL_WIDTH-1:0] ivl_cnt_q, ivl_cnt_d;

    logic             wrap;
    logic             accept;
    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] dist_up;
    logic [WIDTH-1:0] dist_dn;

    pwm_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable),
        .duty_i         (duty_q),
        .wrap_o         (wrap),
        .period_start_o (period_start),
        .pwm_o          (pwm)
    );

    // Gated by rst_n so ready reads 0 while reset is held even with enable high.
    assign tgt_ready = rst_n & enable & ((state_q == StIdle) | (state_q == StHold));
    assign accept    = tgt_valid & tgt_ready;
    assign step_eff  = (step_q == '0) ? WIDTH'(1) : step_q;
    // Only the distance on the side of the target is consulted, so no wrap is possible.
    assign dist_up   = tgt_q - duty_q;
    assign dist_dn   = duty_q - tgt_q;

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        tgt_d     = tgt_q;
        step_d    = step_q;
        ivl_d     = ivl_q;
        ivl_cnt_d = ivl_cnt_q;
        if (!enable) begin
            state_d = StIdle;
        end else if (accept) begin
            // Acceptance never happens in RAMP, so a coincident wrap cannot step here.
            tgt_d     = tgt_duty;
            step_d    = tgt_step;
            ivl_d     = tgt_ivl;
            ivl_cnt_d = '0;
            state_d   = (tgt_duty != duty_q) ? StRamp : StHold;
        end else if ((state_q == StRamp) && wrap) begin
            if (ivl_cnt_q != ivl_q) begin
                ivl_cnt_d = ivl_cnt_q + IVL_WIDTH'(1);
            end else begin
                ivl_cnt_d = '0;
                if (tgt_q > duty_q) begin
                    if (dist_up <= step_eff) begin
                        duty_d  = tgt_q;
                        state_d = StHold;
                    end else begin
                        duty_d = duty_q + step_eff;
                    end
                end else begin
                    if (dist_dn <= step_eff) begin
                        duty_d  = tgt_q;
                        state_d = StHold;
                    end else begin
                        duty_d = duty_q - step_eff;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            duty_q    <= '0;
            tgt_q     <= '0;
            step_q    <= '0;
            ivl_q     <= '0;
            ivl_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            tgt_q     <= tgt_d;
            step_q    <= step_d;
            ivl_q     <= ivl_d;
            ivl_cnt_q <= ivl_cnt_d;
        end
    end

    assign duty_cur = duty_q;
    assign busy     = (state_q == StRamp);

`ifdef PWM_RAMP_DONE_IRQ_EN
    logic done_q, done_d;

    // Entering HOLD from a ramp or via a request; aborts go to IDLE and never pulse.
    assign done_d = enable & (state_d == StHold) & ((state_q == StRamp) | accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done_irq = done_q;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

    localparam int W  = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          tgt_valid = 1'b0;
    logic          tgt_ready;
    logic [W-1:0]  tgt_duty = '0;
    logic [W-1:0]  tgt_step = '0;
    logic [IW-1:0] tgt_ivl = '0;
    logic [W-1:0]  duty_cur;
    logic          pwm;
    logic          period_start;
    logic          busy;
`ifdef PWM_RAMP_DONE_IRQ_EN
    logic          done_irq;
    int            done_cnt = 0;
    always @(posedge clk) if (done_irq === 1'b1) done_cnt++;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .WIDTH     (W),
        .IVL_WIDTH (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .tgt_valid    (tgt_valid),
        .tgt_ready    (tgt_ready),
        .tgt_duty     (tgt_duty),
        .tgt_step     (tgt_step),
        .tgt_ivl      (tgt_ivl),
        .duty_cur     (duty_cur),
        .pwm          (pwm),
        .period_start (period_start),
        .busy         (busy)
`ifdef PWM_RAMP_DONE_IRQ_EN
        ,
        .done_irq     (done_irq)
`endif
    );

    // Advance to the next negedge showing period_start, bounded to just over one period.
    task automatic wait_ps(output bit ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 300);
        ok = (period_start === 1'b1);
    endtask

    // Present a request for one cycle; returns at the following negedge.
    task automatic req_pulse(input int d, input int s, input int i);
        tgt_valid = 1'b1;
        tgt_duty  = W'(d);
        tgt_step  = W'(s);
        tgt_ivl   = IW'(i);
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    task automatic test_reset;
        enable = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({duty_cur, pwm, period_start, busy, tgt_ready} !== {8'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_outputs: got duty=%0d pwm=%b ps=%b busy=%b rdy=%b, want all 0",
                     duty_cur, pwm, period_start, busy, tgt_ready);
        end
`ifdef PWM_RAMP_DONE_IRQ_EN
        n_checks++;
        if (done_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done_irq: got %b want 0", done_irq);
        end
`endif
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (period_start !== 1'b1 || tgt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got ps=%b rdy=%b want 1 1", period_start, tgt_ready);
        end
    endtask

    task automatic test_first_ramp;
        bit ok;
        int hi = 0;
        req_pulse(64, 64, 0);
        n_checks++;
        if (busy !== 1'b1 || tgt_ready !== 1'b0 || duty_cur !== 8'd0) begin
            n_fail++;
            $display("FAIL accept_64: got busy=%b rdy=%b duty=%0d want 1 0 0",
                     busy, tgt_ready, duty_cur);
        end
        wait_ps(ok);
        n_checks++;
        if (!ok || duty_cur !== 8'd64 || busy !== 1'b0 || tgt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_wrap: got ok=%b duty=%0d busy=%b rdy=%b want 1 64 0 1",
                     ok, duty_cur, busy, tgt_ready);
        end
`ifdef PWM_RAMP_DONE_IRQ_EN
        n_checks++;
        if (done_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL done_first: got %b want 1", done_irq);
        end
`endif
        repeat (256) begin
            @(negedge clk);
            if (pwm === 1'b1) hi++;
        end
        n_checks++;
        if (hi != 64 || period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL pwm_high_64: got high=%0d ps=%b want 64 1", hi, period_start);
        end
    endtask

    task automatic test_ramp_up;
        bit ok;
        int exp_up [6] = '{64, 114, 114, 164, 164, 200};
`ifdef PWM_RAMP_DONE_IRQ_EN
        int snap = done_cnt;
`endif
        req_pulse(200, 50, 1);
        for (int w = 0; w < 6; w++) begin
            wait_ps(ok);
            n_checks++;
            if (!ok || duty_cur !== W'(exp_up[w]) || busy !== (w != 5)) begin
                n_fail++;
                $display("FAIL ramp_up wrap %0d: got ok=%b duty=%0d busy=%b want duty=%0d busy=%b",
                         w, ok, duty_cur, busy, exp_up[w], (w != 5));
            end
        end
        @(negedge clk);
`ifdef PWM_RAMP_DONE_IRQ_EN
        n_checks++;
        if (done_cnt - snap != 1) begin
            n_fail++;
            $display("FAIL done_ramp_up: got %0d pulses want 1", done_cnt - snap);
        end
`endif
    endtask

    task automatic test_ramp_down_step0;
        bit ok;
        wait_ps(ok);
        req_pulse(10, 0, 0);
        for (int w = 1; w <= 191; w++) begin
            wait_ps(ok);
            n_checks++;
            if (!ok || duty_cur !== W'((w > 190) ? 10 : 200 - w) || busy !== (w < 190)) begin
                n_fail++;
                $display("FAIL ramp_down wrap %0d: got ok=%b duty=%0d busy=%b want duty=%0d busy=%b",
                         w, ok, duty_cur, busy, (w > 190) ? 10 : 200 - w, (w < 190));
            end
        end
    endtask

    task automatic test_abort;
        bit ok;
        int hi = 0;
        req_pulse(200, 110, 0);
        wait_ps(ok);
        n_checks++;
        if (!ok || duty_cur !== 8'd120 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup: got ok=%b duty=%0d busy=%b want 1 120 1", ok, duty_cur, busy);
        end
        repeat (50) @(negedge clk);
        enable = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pwm !== 1'b0) hi++;
        end
        n_checks++;
        if (hi != 0 || busy !== 1'b0 || tgt_ready !== 1'b0 || period_start !== 1'b0
            || duty_cur !== 8'd120) begin
            n_fail++;
            $display("FAIL abort_disabled: got pwm_hi=%0d busy=%b rdy=%b ps=%b duty=%0d want 0 0 0 0 120",
                     hi, busy, tgt_ready, period_start, duty_cur);
        end
        enable = 1'b1;
        #1;
        n_checks++;
        if (period_start !== 1'b1 || tgt_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reenable: got ps=%b rdy=%b busy=%b want 1 1 0", period_start, tgt_ready, busy);
        end
        for (int k = 0; k < 2; k++) begin
            wait_ps(ok);
            n_checks++;
            if (!ok || duty_cur !== 8'd120 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_abort %0d: got ok=%b duty=%0d busy=%b want 1 120 0",
                         k, ok, duty_cur, busy);
            end
        end
    endtask

    task automatic test_wrap_accept;
        bit ok;
        int exp_dn [3] = '{100, 80, 60};
        repeat (255) @(negedge clk);
        req_pulse(60, 20, 0);
        n_checks++;
        if (period_start !== 1'b1 || duty_cur !== 8'd120 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_accept: got ps=%b duty=%0d busy=%b want 1 120 1",
                     period_start, duty_cur, busy);
        end
        for (int w = 0; w < 3; w++) begin
            wait_ps(ok);
            n_checks++;
            if (!ok || duty_cur !== W'(exp_dn[w]) || busy !== (w != 2)) begin
                n_fail++;
                $display("FAIL wrap_accept step %0d: got ok=%b duty=%0d busy=%b want %0d %b",
                         w, ok, duty_cur, busy, exp_dn[w], (w != 2));
            end
        end
    endtask

    task automatic test_hold_request;
        req_pulse(60, 5, 0);
        n_checks++;
        if (busy !== 1'b0 || tgt_ready !== 1'b1 || duty_cur !== 8'd60) begin
            n_fail++;
            $display("FAIL direct_hold: got busy=%b rdy=%b duty=%0d want 0 1 60", busy, tgt_ready, duty_cur);
        end
`ifdef PWM_RAMP_DONE_IRQ_EN
        n_checks++;
        if (done_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL done_direct_hold: got %b want 1", done_irq);
        end
`endif
    endtask

    task automatic test_reset_mid_ramp;
        bit ok;
`ifdef PWM_RAMP_DONE_IRQ_EN
        int snap;
`endif
        wait_ps(ok);
        req_pulse(200, 10, 0);
        wait_ps(ok);
        n_checks++;
        if (!ok || duty_cur !== 8'd70 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: got ok=%b duty=%0d busy=%b want 1 70 1", ok, duty_cur, busy);
        end
        repeat (30) @(negedge clk);
`ifdef PWM_RAMP_DONE_IRQ_EN
        snap = done_cnt;
`endif
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({duty_cur, pwm, period_start, busy, tgt_ready} !== {8'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL rst_mid_ramp: got duty=%0d pwm=%b ps=%b busy=%b rdy=%b want all 0",
                     duty_cur, pwm, period_start, busy, tgt_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        n_checks++;
        if (duty_cur !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_rst: got duty=%0d busy=%b want 0 0", duty_cur, busy);
        end
`ifdef PWM_RAMP_DONE_IRQ_EN
        n_checks++;
        if (done_cnt != snap) begin
            n_fail++;
            $display("FAIL done_on_reset: got %0d pulses want 0", done_cnt - snap);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_first_ramp;
        test_ramp_up;
        test_ramp_down_step0;
        test_abort;
        test_wrap_accept;
        test_hold_request;
        test_reset_mid_ramp;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
